// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply controller computing base^exponent mod modulus
// by sequencing an external bit-serial Montgomery multiplier (R = 2^W).
module mod_exp_ctrl #(
  parameter int W = 2048,
  parameter int E = 2048
) (
  input  logic           clk,
  input  logic           exp_rst,
  input  logic           exp_start,
  input  logic [W-1:0]   base,
  input  logic [E-1:0]   exponent,
  input  logic [W-1:0]   modulus,
  input  logic [W-1:0]   r2,
  output logic [W-1:0]   exp_result,
  output logic           exp_busy,
  output logic           exp_finish,
  output logic [W:0]     mm_x,
  output logic [W:0]     mm_y,
  output logic [W-1:0]   mm_n,
  output logic           mm_rst,
  output logic           mm_start,
  input  logic [W-1:0]   mm_result,
  input  logic           mm_finish,
  output logic [4:0]     dbg_state
);

  localparam int BW = (E > 1) ? $clog2(E) : 1;
  localparam logic [W:0] ONE_X = {{W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    OP_IDLE   = 3'd0,
    OP_BASE   = 3'd1,
    OP_ONE    = 3'd2,
    OP_SQUARE = 3'd3,
    OP_MULT   = 3'd4,
    OP_FROM   = 3'd5,
    OP_DONE   = 3'd6
  } op_e;

  typedef enum logic [1:0] {
    PH_CLR  = 2'd0,
    PH_GO   = 2'd1,
    PH_WAIT = 2'd2
  } ph_e;

  // Multiplier handshake: mm_rst pulses one cycle (MM_CLR) with operands already
  // presented, mm_start pulses the next cycle (MM_GO), then operands are held until
  // the first cycle mm_finish is seen in MM_WAIT; mm_finish elsewhere is ignored.
  op_e           op_q, op_d;
  ph_e           ph_q, ph_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [E-1:0]  exponent_q, exponent_d;
  logic [W-1:0]  modulus_q, modulus_d;
  logic [W-1:0]  r2_q, r2_d;
  logic [W-1:0]  mb_q, mb_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  result_q, result_d;
  logic [W:0]    mm_x_q, mm_x_d;
  logic [W:0]    mm_y_q, mm_y_d;
  logic          mm_rst_q, mm_rst_d;
  logic          mm_start_q, mm_start_d;
  logic          busy_q, busy_d;
  logic          finish_q, finish_d;

  logic [W:0]    res_x;

  assign res_x = {1'b0, mm_result};

  always_comb begin
    op_d       = op_q;
    ph_d       = ph_q;
    bit_d      = bit_q;
    exponent_d = exponent_q;
    modulus_d  = modulus_q;
    r2_d       = r2_q;
    mb_d       = mb_q;
    acc_d      = acc_q;
    result_d   = result_q;
    mm_x_d     = mm_x_q;
    mm_y_d     = mm_y_q;
    mm_rst_d   = 1'b0;
    mm_start_d = 1'b0;
    busy_d     = busy_q;
    finish_d   = finish_q;

    case (op_q)
      OP_IDLE, OP_DONE: begin
        if (exp_start) begin
          exponent_d = exponent;
          modulus_d  = modulus;
          r2_d       = r2;
          finish_d   = 1'b0;
          busy_d     = 1'b1;
          bit_d      = BW'(E - 1);
          op_d       = OP_BASE;
          ph_d       = PH_CLR;
          mm_rst_d   = 1'b1;
          mm_x_d     = {1'b0, base};
          mm_y_d     = {1'b0, r2};
        end
      end
      default: begin
        case (ph_q)
          PH_CLR: begin
            ph_d       = PH_GO;
            mm_start_d = 1'b1;
          end
          PH_GO: begin
            ph_d = PH_WAIT;
          end
          PH_WAIT: begin
            if (mm_finish) begin
              ph_d     = PH_CLR;
              mm_rst_d = 1'b1;
              case (op_q)
                OP_BASE: begin
                  mb_d   = mm_result;
                  op_d   = OP_ONE;
                  mm_x_d = ONE_X;
                  mm_y_d = {1'b0, r2_q};
                end
                OP_ONE: begin
                  acc_d  = mm_result;
                  op_d   = OP_SQUARE;
                  mm_x_d = res_x;
                  mm_y_d = res_x;
                end
                OP_SQUARE, OP_MULT: begin
                  acc_d = mm_result;
                  if (op_q == OP_SQUARE && exponent_q[bit_q]) begin
                    op_d   = OP_MULT;
                    mm_x_d = res_x;
                    mm_y_d = {1'b0, mb_q};
                  end else if (bit_q == '0) begin
                    // Last bit consumed: leave the Montgomery domain via MM(acc, 1).
                    op_d   = OP_FROM;
                    mm_x_d = res_x;
                    mm_y_d = ONE_X;
                  end else begin
                    bit_d  = bit_q - BW'(1);
                    op_d   = OP_SQUARE;
                    mm_x_d = res_x;
                    mm_y_d = res_x;
                  end
                end
                OP_FROM: begin
                  result_d = mm_result;
                  finish_d = 1'b1;
                  busy_d   = 1'b0;
                  op_d     = OP_DONE;
                  mm_rst_d = 1'b0;
                end
                default: begin
                  op_d = OP_IDLE;
                end
              endcase
            end
          end
          default: begin
            ph_d = PH_CLR;
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or posedge exp_rst) begin
    if (exp_rst) begin
      op_q       <= OP_IDLE;
      ph_q       <= PH_CLR;
      bit_q      <= '0;
      exponent_q <= '0;
      modulus_q  <= '0;
      r2_q       <= '0;
      mb_q       <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      mm_x_q     <= '0;
      mm_y_q     <= '0;
      mm_rst_q   <= 1'b0;
      mm_start_q <= 1'b0;
      busy_q     <= 1'b0;
      finish_q   <= 1'b0;
    end else begin
      op_q       <= op_d;
      ph_q       <= ph_d;
      bit_q      <= bit_d;
      exponent_q <= exponent_d;
      modulus_q  <= modulus_d;
      r2_q       <= r2_d;
      mb_q       <= mb_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      mm_x_q     <= mm_x_d;
      mm_y_q     <= mm_y_d;
      mm_rst_q   <= mm_rst_d;
      mm_start_q <= mm_start_d;
      busy_q     <= busy_d;
      finish_q   <= finish_d;
    end
  end

  // The multiplier is held in clear for as long as this block is in reset.
  assign mm_rst     = mm_rst_q | exp_rst;
  assign mm_start   = mm_start_q;
  assign mm_x       = mm_x_q;
  assign mm_y       = mm_y_q;
  assign mm_n       = modulus_q;
  assign exp_result = result_q;
  assign exp_busy   = busy_q;
  assign exp_finish = finish_q;
  assign dbg_state  = {op_q, ph_q};

endmodule
